// File: rtl/vector_lsu_pkg.sv
// Shared types, widths and element-size helpers for the vector load/store unit.
package vector_lsu_pkg;

    localparam int ADDR_W = 32;
    localparam int VLEN   = 32;
    localparam int MAX_VL = 16;
    localparam int VL_W   = $clog2(MAX_VL) + 1;
    localparam int VREG_W = 5;
    localparam int BYTE_W = VLEN / 8;
    // Wide enough for the byte offset of the element one past the last.
    localparam int OFF_W  = $clog2(MAX_VL * BYTE_W) + 1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        WB,
        DONE
    } vlsu_state_t;

    function automatic logic [2:0] vsew_bytes(input logic [1:0] vsew);
        case (vsew)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [BYTE_W-1:0] elem_mask(input logic [1:0] vsew);
        case (vsew)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/vector_lsu_if.sv
// OBI-style single-outstanding data port between the load/store unit and memory.
interface vector_lsu_if;
    import vector_lsu_pkg::*;

    // data_req_o is held with addr/we/be/wdata stable until a cycle with data_gnt_i;
    // exactly one data_rvalid_i (with data_rdata_i) follows each grant, and the
    // master raises no new request before that rvalid.
    logic              data_req_o;
    logic              data_gnt_i;
    logic              data_rvalid_i;
    logic [ADDR_W-1:0] data_addr_o;
    logic              data_we_o;
    logic [BYTE_W-1:0] data_be_o;
    logic [VLEN-1:0]   data_wdata_o;
    logic [VLEN-1:0]   data_rdata_i;

    modport master (
        output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i
    );

endinterface

// File: rtl/vector_lsu_addr_gen.sv
// Effective address of the current element: word address, lane enables and alignment.
module vlsu_addr_gen
    import vector_lsu_pkg::*;
(
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    input  logic              strided,
    input  logic [VL_W-1:0]   elem_idx,
    input  logic [1:0]        vsew,
    output logic [ADDR_W-1:0] word_addr,
    output logic [BYTE_W-1:0] be,
    output logic [1:0]        lane,
    output logic              misaligned
);

    logic [2:0]        esize;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] ea;

    always_comb begin
        esize = vsew_bytes(vsew);
        step  = strided ? stride : {{(ADDR_W-3){1'b0}}, esize};
        // Modulo-2^32 product keeps negative strides correct without sign handling.
        ea    = base + step * ADDR_W'(elem_idx);
        word_addr  = {ea[ADDR_W-1:2], 2'b00};
        lane       = ea[1:0];
        be         = elem_mask(vsew) << lane;
        misaligned = ((esize == 3'd2) && ea[0]) || ((esize == 3'd4) && (ea[1:0] != 2'b00));
    end

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store unit: walks vl elements over a single-outstanding data port,
// packing loaded elements into vector registers and unpacking stored ones.
module vector_lsu
    import vector_lsu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              vlsu_en_i,
    input  logic              vlsu_load_i,
    input  logic              vlsu_store_i,
    input  logic              vlsu_strided_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] stride_i,
    input  logic [VL_W-1:0]   vl_i,
    input  logic [1:0]        vsew_i,
    input  logic [VREG_W-1:0] vreg_addr_i,
    output logic              vlsu_ready_o,
    output logic              vlsu_err_o,
    vector_lsu_if.master      data,
    output logic              vr_wr_en_o,
    output logic [VREG_W-1:0] vr_wr_addr_o,
    output logic [BYTE_W-1:0] vr_wr_be_o,
    output logic [VLEN-1:0]   vr_wr_data_o,
    output logic [VREG_W-1:0] vr_rd_addr_o,
    input  logic [VLEN-1:0]   vr_rd_data_i,
    output vlsu_state_t       dbg_state
);

    vlsu_state_t       state, state_nxt;
    logic              is_load, strided_q, err_q;
    logic [ADDR_W-1:0] base_q, stride_q;
    logic [VL_W-1:0]   vl_q, elem_idx;
    logic [1:0]        vsew_q;
    logic [VREG_W-1:0] vreg_q, reg_idx;
    logic [VLEN-1:0]   buf_q;
    logic [BYTE_W-1:0] buf_be;

    logic              start, bad_req;
    logic [ADDR_W-1:0] word_addr;
    logic [BYTE_W-1:0] lane_be, emask;
    logic [1:0]        lane, boff, boff_nxt;
    logic              misaligned, last_elem, reg_full;
    logic [2:0]        esize;
    logic [OFF_W-1:0]  byte_off;
    logic [VLEN-1:0]   emask32, ld_elem, st_elem;

    vlsu_addr_gen u_addr_gen (
        .base       (base_q),
        .stride     (stride_q),
        .strided    (strided_q),
        .elem_idx   (elem_idx),
        .vsew       (vsew_q),
        .word_addr  (word_addr),
        .be         (lane_be),
        .lane       (lane),
        .misaligned (misaligned)
    );

    assign start   = vlsu_en_i && (vlsu_load_i || vlsu_store_i);
    assign bad_req = (vlsu_load_i && vlsu_store_i) || (vsew_i == 2'd3);

    // Byte position of the element inside the register group: [1:0] picks the
    // byte within a register, the upper bits pick the register.
    always_comb begin
        esize     = vsew_bytes(vsew_q);
        emask     = elem_mask(vsew_q);
        byte_off  = OFF_W'(elem_idx) * OFF_W'(esize);
        boff      = byte_off[1:0];
        boff_nxt  = boff + esize[1:0];
        reg_full  = (boff_nxt == 2'd0);
        last_elem = ((elem_idx + VL_W'(1)) == vl_q);
        for (int i = 0; i < BYTE_W; i++) begin
            emask32[8*i +: 8] = {8{emask[i]}};
        end
        ld_elem = ((data.data_rdata_i >> {lane, 3'b000}) & emask32) << {boff, 3'b000};
        st_elem = ((vr_rd_data_i >> {boff, 3'b000}) & emask32) << {lane, 3'b000};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (bad_req || (vl_i == '0)) state_nxt = DONE;
                    else                         state_nxt = REQ;
                end
            end
            REQ: begin
                if (misaligned)           state_nxt = DONE;
                else if (data.data_gnt_i) state_nxt = RESP;
            end
            RESP: begin
                if (data.data_rvalid_i) begin
                    if (is_load && (last_elem || reg_full)) state_nxt = WB;
                    else if (last_elem)                     state_nxt = DONE;
                    else                                    state_nxt = REQ;
                end
            end
            WB:      state_nxt = (elem_idx == vl_q) ? DONE : REQ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_load   <= 1'b0;
            strided_q <= 1'b0;
            err_q     <= 1'b0;
            base_q    <= '0;
            stride_q  <= '0;
            vl_q      <= '0;
            vsew_q    <= '0;
            vreg_q    <= '0;
            elem_idx  <= '0;
            reg_idx   <= '0;
            buf_q     <= '0;
            buf_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        is_load   <= vlsu_load_i;
                        strided_q <= vlsu_strided_i;
                        base_q    <= base_addr_i;
                        stride_q  <= stride_i;
                        vl_q      <= vl_i;
                        vsew_q    <= vsew_i;
                        vreg_q    <= vreg_addr_i;
                        elem_idx  <= '0;
                        reg_idx   <= '0;
                        buf_q     <= '0;
                        buf_be    <= '0;
                        err_q     <= bad_req;
                    end
                end
                REQ: begin
                    if (misaligned) err_q <= 1'b1;
                end
                RESP: begin
                    if (data.data_rvalid_i) begin
                        if (is_load) begin
                            buf_q  <= buf_q | ld_elem;
                            buf_be <= buf_be | (emask << boff);
                        end
                        elem_idx <= elem_idx + VL_W'(1);
                    end
                end
                WB: begin
                    buf_q   <= '0;
                    buf_be  <= '0;
                    reg_idx <= reg_idx + VREG_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        data.data_req_o   = 1'b0;
        data.data_addr_o  = '0;
        data.data_we_o    = 1'b0;
        data.data_be_o    = '0;
        data.data_wdata_o = '0;
        vr_wr_en_o        = 1'b0;
        vr_wr_addr_o      = '0;
        vr_wr_be_o        = '0;
        vr_wr_data_o      = '0;
        vr_rd_addr_o      = '0;
        vlsu_ready_o      = 1'b0;
        vlsu_err_o        = 1'b0;
        dbg_state         = state;
        case (state)
            REQ: begin
                if (!is_load) vr_rd_addr_o = vreg_q + byte_off[OFF_W-1:2];
                if (!misaligned) begin
                    data.data_req_o   = 1'b1;
                    data.data_addr_o  = word_addr;
                    data.data_we_o    = !is_load;
                    data.data_be_o    = lane_be;
                    data.data_wdata_o = is_load ? '0 : st_elem;
                end
            end
            WB: begin
                vr_wr_en_o   = 1'b1;
                vr_wr_addr_o = vreg_q + reg_idx;
                vr_wr_be_o   = buf_be;
                vr_wr_data_o = buf_q;
            end
            DONE: begin
                vlsu_ready_o = 1'b1;
                vlsu_err_o   = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vector_lsu.sv
// Directed bench for vector_lsu: reactive memory slave, register file model and
// scoreboard queues of expected bus requests and register writes.
module tb_vector_lsu;
    import vector_lsu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic              en, load, store, strided;
    logic [31:0]       base, stride;
    logic [VL_W-1:0]   vl;
    logic [1:0]        vsew;
    logic [4:0]        vreg;
    logic              ready, err, wr_en;
    logic [4:0]        wr_addr, rd_addr;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data, rd_data;
    vlsu_state_t       dbg_state;
    logic [31:0]       vrf [32];

    vector_lsu_if bus ();

    assign rd_data = vrf[rd_addr];

    vector_lsu dut (
        .clk            (clk),
        .reset          (reset),
        .vlsu_en_i      (en),
        .vlsu_load_i    (load),
        .vlsu_store_i   (store),
        .vlsu_strided_i (strided),
        .base_addr_i    (base),
        .stride_i       (stride),
        .vl_i           (vl),
        .vsew_i         (vsew),
        .vreg_addr_i    (vreg),
        .vlsu_ready_o   (ready),
        .vlsu_err_o     (err),
        .data           (bus),
        .vr_wr_en_o     (wr_en),
        .vr_wr_addr_o   (wr_addr),
        .vr_wr_be_o     (wr_be),
        .vr_wr_data_o   (wr_data),
        .vr_rd_addr_o   (rd_addr),
        .vr_rd_data_i   (rd_data),
        .dbg_state      (dbg_state)
    );

    int total = 0;
    int bad = 0;
    int ready_cnt = 0;
    int gnt_delay = 0;
    int rv_delay = 0;

    logic [68:0] exp_req_q[$], obs_req_q[$];
    logic [40:0] exp_wr_q[$], obs_wr_q[$];

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    // Memory byte at address a holds a[7:0] + 0x10.
    function automatic logic [31:0] word_at(input logic [31:0] wa);
        logic [7:0] lo;
        lo = wa[7:0];
        return {lo + 8'h13, lo + 8'h12, lo + 8'h11, lo + 8'h10};
    endfunction

    task automatic exp_req(input logic [31:0] a, input logic [3:0] be, input logic we, input logic [31:0] wd);
        exp_req_q.push_back({a, be, we, wd});
    endtask

    task automatic exp_wr(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
        exp_wr_q.push_back({a, be, d});
    endtask

    // Reactive data slave with programmable grant and rvalid latency.
    initial begin : slave
        logic [68:0] hold;
        logic [31:0] a;
        int gnt_wait;
        gnt_wait = 0;
        hold = '0;
        bus.data_gnt_i = 1'b0;
        bus.data_rvalid_i = 1'b0;
        bus.data_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (bus.data_req_o) begin
                if (gnt_wait == 0)
                    hold = {bus.data_addr_o, bus.data_be_o, bus.data_we_o, bus.data_wdata_o};
                else
                    check("hold_stable", {bus.data_addr_o, bus.data_be_o, bus.data_we_o, bus.data_wdata_o}, hold);
                if (gnt_wait < gnt_delay) begin
                    gnt_wait++;
                end else begin
                    gnt_wait = 0;
                    a = bus.data_addr_o;
                    obs_req_q.push_back({a, bus.data_be_o, bus.data_we_o,
                                         bus.data_we_o ? (bus.data_wdata_o & be_mask(bus.data_be_o)) : 32'h0});
                    bus.data_gnt_i = 1'b1;
                    @(posedge clk);
                    #1 bus.data_gnt_i = 1'b0;
                    repeat (rv_delay) begin
                        @(posedge clk);
                        #1 check("no_req_in_wait", bus.data_req_o, 1'b0);
                    end
                    bus.data_rvalid_i = 1'b1;
                    bus.data_rdata_i = word_at(a);
                    @(posedge clk);
                    #1;
                    bus.data_rvalid_i = 1'b0;
                    bus.data_rdata_i = '0;
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (wr_en) obs_wr_q.push_back({wr_addr, wr_be, wr_data & be_mask(wr_be)});
            if (ready) ready_cnt++;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic run_op(input logic ld, input logic st, input logic sd, input logic [31:0] b,
                          input logic [31:0] s, input logic [VL_W-1:0] n, input logic [1:0] sew,
                          input logic [4:0] vr, output int lat, output logic e);
        @(posedge clk);
        #1;
        load = ld; store = st; strided = sd; base = b; stride = s;
        vl = n; vsew = sew; vreg = vr; en = 1'b1;
        lat = 0;
        while (lat < 300) begin
            @(negedge clk);
            lat++;
            if (ready) break;
        end
        check("ready_seen", ready, 1'b1);
        e = err;
        @(posedge clk);
        #1;
        en = 1'b0; load = 1'b0; store = 1'b0;
        @(negedge clk);
        check("ready_pulse_low", ready, 1'b0);
    endtask

    task automatic compare_logs(input string tag);
        check({tag, "_nreq"}, obs_req_q.size(), exp_req_q.size());
        while (exp_req_q.size() > 0 && obs_req_q.size() > 0)
            check({tag, "_req"}, obs_req_q.pop_front(), exp_req_q.pop_front());
        check({tag, "_nwr"}, obs_wr_q.size(), exp_wr_q.size());
        while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0)
            check({tag, "_wr"}, obs_wr_q.pop_front(), exp_wr_q.pop_front());
        check({tag, "_nready"}, ready_cnt, 1);
        exp_req_q.delete(); obs_req_q.delete();
        exp_wr_q.delete(); obs_wr_q.delete();
        ready_cnt = 0;
    endtask

    initial begin : main
        int lat;
        int waited;
        logic e;
        en = 1'b0; load = 1'b0; store = 1'b0; strided = 1'b0;
        base = '0; stride = '0; vl = '0; vsew = '0; vreg = '0;
        for (int i = 0; i < 32; i++) vrf[i] = 32'h0;
        vrf[4] = 32'h2222_1111;
        vrf[5] = 32'h4444_3333;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready, 1'b0);
        check("rst_req", bus.data_req_o, 1'b0);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_addr", bus.data_addr_o, 32'h0);
        check("rst_state", dbg_state, IDLE);
        @(posedge clk);
        #1 reset = 1'b0;

        // Unit-stride byte load across a register boundary, vreg index wraps 31 -> 0.
        exp_req(32'h100, 4'h1, 1'b0, 32'h0);
        exp_req(32'h100, 4'h2, 1'b0, 32'h0);
        exp_req(32'h100, 4'h4, 1'b0, 32'h0);
        exp_req(32'h100, 4'h8, 1'b0, 32'h0);
        exp_req(32'h104, 4'h1, 1'b0, 32'h0);
        exp_wr(5'd31, 4'hF, 32'h1312_1110);
        exp_wr(5'd0,  4'h1, 32'h0000_0014);
        run_op(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 5'd5, 2'd0, 5'd31, lat, e);
        check("t1_lat", lat, 14);
        check("t1_err", e, 1'b0);
        compare_logs("t1");

        // Strided halfword store with negative stride.
        exp_req(32'h40, 4'h3, 1'b1, 32'h0000_1111);
        exp_req(32'h38, 4'h3, 1'b1, 32'h0000_2222);
        exp_req(32'h30, 4'h3, 1'b1, 32'h0000_3333);
        run_op(1'b0, 1'b1, 1'b1, 32'h40, 32'hFFFF_FFF8, 5'd3, 2'd1, 5'd4, lat, e);
        check("t2_err", e, 1'b0);
        compare_logs("t2");

        // Halfword store onto the upper lanes.
        exp_req(32'h40, 4'hC, 1'b1, 32'h1111_0000);
        exp_req(32'h44, 4'hC, 1'b1, 32'h2222_0000);
        run_op(1'b0, 1'b1, 1'b1, 32'h42, 32'h4, 5'd2, 2'd1, 5'd4, lat, e);
        compare_logs("t3");

        // Unit-stride halfword load starting on lane 2.
        exp_req(32'h300, 4'hC, 1'b0, 32'h0);
        exp_req(32'h304, 4'h3, 1'b0, 32'h0);
        exp_req(32'h304, 4'hC, 1'b0, 32'h0);
        exp_wr(5'd8, 4'hF, 32'h1514_1312);
        exp_wr(5'd9, 4'h3, 32'h0000_1716);
        run_op(1'b1, 1'b0, 1'b0, 32'h302, 32'h0, 5'd3, 2'd1, 5'd8, lat, e);
        compare_logs("t4");

        // vl = 0: completion on the second cycle, no traffic.
        run_op(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 5'd0, 2'd0, 5'd2, lat, e);
        check("t5_lat", lat, 2);
        check("t5_err", e, 1'b0);
        compare_logs("t5");

        // Misaligned word base aborts before any request.
        run_op(1'b1, 1'b0, 1'b0, 32'h102, 32'h0, 5'd2, 2'd2, 5'd2, lat, e);
        check("t6_err", e, 1'b1);
        compare_logs("t6");

        // Load and store both requested.
        run_op(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd2, 2'd0, 5'd2, lat, e);
        check("t7_lat", lat, 2);
        check("t7_err", e, 1'b1);
        compare_logs("t7");

        // Reserved element width.
        run_op(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 5'd2, 2'd3, 5'd2, lat, e);
        check("t8_err", e, 1'b1);
        compare_logs("t8");

        // Second strided element misaligned: first register write is kept.
        exp_req(32'h200, 4'hF, 1'b0, 32'h0);
        exp_wr(5'd10, 4'hF, 32'h1312_1110);
        run_op(1'b1, 1'b0, 1'b1, 32'h200, 32'h6, 5'd3, 2'd2, 5'd10, lat, e);
        check("t9_err", e, 1'b1);
        compare_logs("t9");

        // Back-pressure on grant and rvalid.
        gnt_delay = 3;
        rv_delay = 2;
        exp_req(32'h40, 4'hC, 1'b1, 32'h1111_0000);
        exp_req(32'h44, 4'hC, 1'b1, 32'h2222_0000);
        run_op(1'b0, 1'b1, 1'b1, 32'h42, 32'h4, 5'd2, 2'd1, 5'd4, lat, e);
        check("t10_lat", lat, 16);
        compare_logs("t10");
        gnt_delay = 0;

        // Reset while waiting for rvalid; the late rvalid must be ignored.
        rv_delay = 3;
        @(posedge clk);
        #1;
        load = 1'b1; store = 1'b0; strided = 1'b0; base = 32'h200; stride = 32'h0;
        vl = 5'd1; vsew = 2'd2; vreg = 5'd12; en = 1'b1;
        waited = 0;
        while (waited < 20) begin
            @(negedge clk);
            waited++;
            if (dbg_state == RESP) break;
        end
        check("t11_reach_resp", dbg_state, RESP);
        reset = 1'b1;
        en = 1'b0; load = 1'b0;
        #1;
        check("t11_rst_req", bus.data_req_o, 1'b0);
        check("t11_rst_wr", wr_en, 1'b0);
        check("t11_rst_ready", ready, 1'b0);
        check("t11_rst_state", dbg_state, IDLE);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (8) @(negedge clk);
        check("t11_no_wr", obs_wr_q.size(), 0);
        check("t11_no_ready", ready_cnt, 0);
        check("t11_nreq", obs_req_q.size(), 1);
        obs_req_q.delete();
        obs_wr_q.delete();
        ready_cnt = 0;
        rv_delay = 0;

        // Clean restart after the reset.
        exp_req(32'h200, 4'hF, 1'b0, 32'h0);
        exp_req(32'h204, 4'hF, 1'b0, 32'h0);
        exp_wr(5'd12, 4'hF, 32'h1312_1110);
        exp_wr(5'd13, 4'hF, 32'h1716_1514);
        run_op(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 5'd2, 2'd2, 5'd12, lat, e);
        check("t12_err", e, 1'b0);
        compare_logs("t12");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
